instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Program sequencer for the 4-op CPU control FSM (LOAD/MOVE/ADD/XOR). Holds a small
//  writable program store, fetches instructions in order, issues each one to the control
//  FSM for exactly one cycle, then waits for its done pulse before advancing the PC.
//  Drives NOP between issues so the control FSM never re-executes a held instruction.
// PARAMETERS
//  OP_SIZE   4   opcode width
//  ARG_SIZE  3   register-argument width
//  ARG_NUM   2   arguments per instruction; INSTR_W = OP_SIZE+ARG_NUM*ARG_SIZE (10)
//  DEPTH     16  program store entries; ADDR_W = $clog2(DEPTH)
//  TIMEOUT   15  max cycles in WAIT before fault (counter width $clog2(TIMEOUT+1))
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  start        in   1        pulse: run program from address 0
//  prog_we      in   1        program store write enable
//  prog_addr    in   ADDR_W   program store write address
//  prog_data    in   INSTR_W  program store write data
//  done_in      in   1        done from control FSM (instruction complete)
//  instruction  out  INSTR_W  instruction to control FSM; NOP when not issuing
//  pc           out  ADDR_W   current program counter
//  busy         out  1        high in FETCH/ISSUE/WAIT(/PAUSE)
//  halted       out  1        program ended (HALT opcode or last address completed)
//  fault        out  1        WAIT timeout
// BEHAVIOUR
//  - Reset: state=IDLE, pc=0, instruction=NOP, busy=halted=fault=0, timeout count=0.
//    Program store is NOT reset; contents survive rst. Reset mid-instruction aborts at once.
//  - Encodings: NOP = {4'b1110,6'b0}; HALT opcode = 4'b1111. Opcodes 4'b0100-4'b1101 are
//    issued unchanged (control FSM ignores them) and complete without done -> timeout.
//  - States: IDLE, FETCH, ISSUE, WAIT, HALTED, FAULT.
//    IDLE:   start=1 -> FETCH, pc=0, halted=fault=0.
//    FETCH:  store read at pc (registered, 1 cycle) -> ISSUE.
//    ISSUE:  instruction=mem[pc] for exactly 1 cycle. HALT opcode -> HALTED (NOP driven
//            instead, nothing issued); else -> WAIT, timeout count cleared.
//    WAIT:   instruction=NOP. done_in=1: if pc==DEPTH-1 -> HALTED, else pc<=pc+1, -> FETCH.
//            Count reaches TIMEOUT without done_in -> FAULT.
//    HALTED: halted=1, pc holds; start -> as from IDLE.  FAULT: fault=1, pc holds; start
//            -> as from IDLE (fault cleared).
//  - Latency: start at cycle t -> FETCH t+1, instruction valid t+2; LOAD/MOVE done at t+3
//    -> next instruction issued t+5 (done->issue = 2 cycles). ADD/XOR: done 3 cycles after issue.
//  - done_in outside WAIT is ignored. start while busy is ignored.
//  - prog_we honoured only when busy=0; writes while busy are dropped. prog_we and start in
//    the same IDLE cycle: write lands first, FETCH of addr 0 sees new data.
//  - pc wraps never: completion at DEPTH-1 ends the program (HALTED).
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: adds ports step_en (in,1) and step (in,1) and state PAUSE.
//    With step_en=1, WAIT+done_in goes to PAUSE (busy=1, NOP driven, pc already advanced);
//    a step pulse -> FETCH. step_en=0 in PAUSE -> FETCH next cycle. Final-instruction
//    completion still goes to HALTED, never PAUSE.
//  Undefined: ports and PAUSE absent; free-running sequence only.
// TESTING
//  1 Load {LOAD r1},{MOVE r2,r1},{HALT}; start -> issues at t+2 and t+5, halted=1, pc=2,
//    instruction never non-NOP for more than 1 consecutive cycle.
//  2 ADD r3,r4 at addr0 with control-FSM model -> done 3 cycles after issue, next issue 2
//    cycles later; pc=1.
//  3 Opcode 4'b0101 at addr0 -> no done; fault=1 exactly TIMEOUT cycles after WAIT entry;
//    start clears fault and reruns from pc=0.
//  4 16 LOAD instructions, no HALT -> done at pc=15 gives halted=1, pc=15 (no wrap).
//  5 rst asserted during WAIT of ADD -> same cycle state=IDLE, instruction=NOP, pc=0;
//    store contents unchanged on re-run; prog_we while busy leaves store unchanged.
//  6 SEQ_SINGLE_STEP_EN, step_en=1: after each done, busy=1 and NOP until step pulse;
//    three steps execute three instructions.

Source files
------------

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Program sequencer for the 4-op control FSM (LOAD/MOVE/ADD/XOR).
//             Holds a writable program store, fetches instructions in order,
//             issues each for exactly one cycle, then waits for done_in before
//             advancing the PC. NOP is driven whenever nothing is being issued.
//  Ports    : clk, rst (async, active-high)
//             start        - pulse, run program from address 0
//             prog_we/prog_addr/prog_data - store write port (idle only)
//             done_in      - completion from the control FSM
//             instruction  - issued instruction, NOP otherwise
//             pc           - program counter
//             busy/halted/fault - status
//  Option   : SEQ_SINGLE_STEP_EN adds step_en/step inputs and a PAUSE state
//             entered after each completed instruction while step_en=1.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int OP_SIZE  = 4,
  parameter int ARG_SIZE = 3,
  parameter int ARG_NUM  = 2,
  parameter int DEPTH    = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 prog_we,
  input  logic [$clog2(DEPTH)-1:0]             prog_addr,
  input  logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0]  prog_data,
  input  logic                                 done_in,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                                 step_en,
  input  logic                                 step,
`endif
  output logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0]  instruction,
  output logic [$clog2(DEPTH)-1:0]             pc,
  output logic                                 busy,
  output logic                                 halted,
  output logic                                 fault
);

  localparam int INSTR_W = OP_SIZE + ARG_NUM * ARG_SIZE;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  localparam logic [OP_SIZE-1:0] HALT_OP = {OP_SIZE{1'b1}};
  localparam logic [OP_SIZE-1:0] NOP_OP  = {{(OP_SIZE-1){1'b1}}, 1'b0};
  localparam logic [INSTR_W-1:0] NOP     = {NOP_OP, {(INSTR_W-OP_SIZE){1'b0}}};
  localparam logic [ADDR_W-1:0]  LAST_PC = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALTED,
    S_FAULT
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  pc_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] fetched;
  logic               is_halt;

  // Program store is deliberately not reset so a program survives rst.
  // Writes are dropped while a program is running.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem[prog_addr] <= prog_data;
    end
    if (state == S_FETCH) begin
      fetched <= mem[pc];
    end
  end

  assign is_halt = (fetched[INSTR_W-1 -: OP_SIZE] == HALT_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = cnt;
    case (state)
      S_IDLE, S_HALTED, S_FAULT: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
        end
      end
      S_FETCH: state_next = S_ISSUE;
      S_ISSUE: begin
        cnt_next   = '0;
        state_next = is_halt ? S_HALTED : S_WAIT;
      end
      S_WAIT: begin
        if (done_in) begin
          if (pc == LAST_PC) begin
            // Last address completed: the program ends, pc never wraps.
            state_next = S_HALTED;
          end else begin
            pc_next = pc + 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
            state_next = step_en ? S_PAUSE : S_FETCH;
`else
            state_next = S_FETCH;
`endif
          end
        end else if (cnt == CNT_MAX) begin
          // cnt counts WAIT cycles already spent; this is the last allowed one.
          state_next = S_FAULT;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step || !step_en) begin
          state_next = S_FETCH;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    instruction = NOP;
    if (state == S_ISSUE && !is_halt) begin
      instruction = fetched;
    end
    busy   = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT)
`ifdef SEQ_SINGLE_STEP_EN
             || (state == S_PAUSE)
`endif
             ;
    halted = (state == S_HALTED);
    fault  = (state == S_FAULT);
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_sequencer
//  Purpose  : Self-checking bench for instr_sequencer. A timing model derived
//             from the sequencing rules predicts every issue cycle, the final
//             status and pc; a control-FSM model answers with done_in.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  localparam int         TIMEOUT = 15;
  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_MOVE = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [9:0] NOP     = 10'b1110_000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       prog_we = 1'b0;
  logic       done_in = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [9:0] prog_data = '0;
  logic [9:0] instruction;
  logic [3:0] pc;
  logic       busy, halted, fault;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step_en = 1'b0;
  logic       step = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] prog [16];
  int         exp_off[$];
  logic [9:0] exp_ins[$];
  int         exp_pc[$];
  bit         exp_halt;
  int         exp_end_off;
  int         exp_end_pc;
  int         obs_off[$];
  int         obs_halt_off;
  int         obs_fault_off;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .done_in     (done_in),
`ifdef SEQ_SINGLE_STEP_EN
    .step_en     (step_en),
    .step        (step),
`endif
    .instruction (instruction),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault)
  );

  function automatic logic [9:0] mk(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b);
    return {op, a, b};
  endfunction

  // Control FSM response time: LOAD/MOVE 1 cycle, ADD/XOR 3 cycles, others never.
  function automatic int lat_of(input logic [3:0] op);
    if (op == OP_LOAD || op == OP_MOVE) return 1;
    if (op == OP_ADD || op == OP_XOR) return 3;
    return 0;
  endfunction

  // Offsets are relative to the cycle in which start is high.
  task automatic build_model();
    int p, t, lat;
    bit fin;
    logic [9:0] w;
    exp_off.delete(); exp_ins.delete(); exp_pc.delete();
    p = 0; t = 2; fin = 0;
    while (!fin) begin
      w = prog[p];
      if (w[9:6] == OP_HALT) begin
        exp_halt = 1; exp_end_off = t + 1; exp_end_pc = p; fin = 1;
      end else begin
        exp_off.push_back(t); exp_ins.push_back(w); exp_pc.push_back(p);
        lat = lat_of(w[9:6]);
        if (lat == 0) begin
          exp_halt = 0; exp_end_off = t + 1 + TIMEOUT; exp_end_pc = p; fin = 1;
        end else if (p == 15) begin
          exp_halt = 1; exp_end_off = t + lat + 1; exp_end_pc = p; fin = 1;
        end else begin
          p++; t = t + lat + 2;
        end
      end
    end
  endtask

  task automatic load_program();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Runs the stored program from a start pulse and checks it against the model.
  // start_off/wr_off inject a start / a store write while busy (0 = none);
  // stray raises done_in in issue cycles; first_wr writes prog[0] with start.
  task automatic run_check(input int start_off, input int wr_off, input bit stray, input bit first_wr);
    int done_due, run_nn, max_run, seen, budget, lat;
    build_model();
    budget = exp_end_off + 4;
    obs_off.delete(); obs_halt_off = -1; obs_fault_off = -1;
    done_due = -1; run_nn = 0; max_run = 0; seen = 0;
    @(negedge clk);
    start = 1'b1;
    if (first_wr) begin
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = prog[0];
    end
    for (int off = 1; off <= budget; off++) begin
      @(negedge clk);
      start     = (off == start_off);
      prog_we   = (off == wr_off);
      prog_addr = 4'd0;
      prog_data = mk(OP_HALT, 3'd0, 3'd0);
      if (off == 1) begin
        n_tests++;
        if (busy !== 1'b1 || halted !== 1'b0 || fault !== 1'b0) begin
          n_fail++;
          $display("FAIL run_start: busy/halted/fault=%b%b%b required 100", busy, halted, fault);
        end
      end
      if (instruction !== NOP) begin
        run_nn++;
        obs_off.push_back(off);
        n_tests++;
        if (seen >= exp_off.size()) begin
          n_fail++;
          $display("FAIL extra_issue: got %h at offset %0d, none expected", instruction, off);
        end else if (off != exp_off[seen] || instruction !== exp_ins[seen] || pc !== 4'(exp_pc[seen])) begin
          n_fail++;
          $display("FAIL issue[%0d]: got %h pc=%0d at offset %0d, required %h pc=%0d at offset %0d",
                   seen, instruction, pc, off, exp_ins[seen], exp_pc[seen], exp_off[seen]);
        end
        seen++;
        lat = lat_of(instruction[9:6]);
        if (lat > 0) done_due = off + lat;
      end else begin
        run_nn = 0;
      end
      if (run_nn > max_run) max_run = run_nn;
      if (halted === 1'b1 && obs_halt_off < 0) obs_halt_off = off;
      if (fault === 1'b1 && obs_fault_off < 0) obs_fault_off = off;
      done_in = (off == done_due) || (stray && instruction !== NOP);
    end
    done_in = 1'b0; start = 1'b0; prog_we = 1'b0;
    n_tests++;
    if (seen != exp_off.size()) begin
      n_fail++; $display("FAIL issue_count: got %0d required %0d", seen, exp_off.size());
    end
    n_tests++;
    if (obs_halt_off != (exp_halt ? exp_end_off : -1)) begin
      n_fail++; $display("FAIL halt_offset: got %0d required %0d", obs_halt_off, exp_halt ? exp_end_off : -1);
    end
    n_tests++;
    if (obs_fault_off != (exp_halt ? -1 : exp_end_off)) begin
      n_fail++; $display("FAIL fault_offset: got %0d required %0d", obs_fault_off, exp_halt ? -1 : exp_end_off);
    end
    n_tests++;
    if (pc !== 4'(exp_end_pc) || busy !== 1'b0) begin
      n_fail++; $display("FAIL end_state: pc=%0d busy=%b required pc=%0d busy=0", pc, busy, exp_end_pc);
    end
    n_tests++;
    if (max_run > 1) begin
      n_fail++; $display("FAIL held_issue: non-NOP for %0d consecutive cycles, required 1", max_run);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (instruction !== NOP || pc !== 4'd0) begin
      n_fail++; $display("FAIL reset_instr_pc: instr=%h pc=%0d required %h 0", instruction, pc, NOP);
    end
    n_tests++;
    if (busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: busy/halted/fault=%b%b%b required 000", busy, halted, fault);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_move_halt();
    for (int i = 0; i < 16; i++) prog[i] = mk(OP_LOAD, 3'd7, 3'd7);
    prog[0] = mk(OP_LOAD, 3'd1, 3'd0);
    prog[1] = mk(OP_MOVE, 3'd2, 3'd1);
    prog[2] = mk(OP_HALT, 3'd0, 3'd0);
    load_program();
    run_check(0, 0, 0, 0);
    n_tests++;
    if (obs_off.size() != 2 || obs_off[0] != 2 || obs_off[1] != 5) begin
      n_fail++; $display("FAIL lmh_issue_cycles: got %0d issues (first %0d) required 2 at 2,5",
                         obs_off.size(), obs_off.size() > 0 ? obs_off[0] : -1);
    end
    n_tests++;
    if (halted !== 1'b1 || pc !== 4'd2) begin
      n_fail++; $display("FAIL lmh_end: halted=%b pc=%0d required 1 2", halted, pc);
    end
  endtask

  task automatic test_add();
    prog[0] = mk(OP_ADD, 3'd3, 3'd4);
    prog[1] = mk(OP_HALT, 3'd0, 3'd0);
    load_program();
    run_check(0, 0, 0, 0);
    n_tests++;
    if (obs_halt_off != 8 || pc !== 4'd1) begin
      n_fail++; $display("FAIL add_end: halted at %0d pc=%0d required 8 1", obs_halt_off, pc);
    end
  endtask

  task automatic test_timeout();
    prog[0] = mk(4'b0101, 3'd5, 3'd2);
    load_program();
    for (int r = 0; r < 2; r++) begin
      run_check(0, 0, 0, 0);
      n_tests++;
      if (obs_fault_off != 2 + 1 + TIMEOUT || fault !== 1'b1 || pc !== 4'd0) begin
        n_fail++; $display("FAIL timeout_run%0d: fault at %0d fault=%b pc=%0d required %0d 1 0",
                           r, obs_fault_off, fault, pc, 2 + 1 + TIMEOUT);
      end
    end
  endtask

  task automatic test_no_wrap();
    for (int i = 0; i < 16; i++) prog[i] = mk(OP_LOAD, 3'(i), 3'(i + 1));
    load_program();
    run_check(0, 0, 1, 0);
    n_tests++;
    if (halted !== 1'b1 || pc !== 4'd15) begin
      n_fail++; $display("FAIL no_wrap: halted=%b pc=%0d required 1 15", halted, pc);
    end
  endtask

  task automatic test_same_cycle_write();
    prog[0] = mk(OP_HALT, 3'd0, 3'd0);
    run_check(0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 16; i++) prog[i] = mk(OP_LOAD, 3'd2, 3'd3);
    prog[0] = mk(OP_ADD, 3'd3, 3'd4);
    prog[1] = mk(OP_ADD, 3'd1, 3'd2);
    prog[2] = mk(OP_HALT, 3'd0, 3'd0);
    load_program();
    @(negedge clk);
    start = 1'b1;
    for (int off = 1; off <= 9; off++) begin
      @(negedge clk);
      start   = 1'b0;
      done_in = (off == 5);
    end
    n_tests++;
    if (pc !== 4'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: pc=%0d busy=%b required 1 1", pc, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (instruction !== NOP || pc !== 4'd0 || busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: instr=%h pc=%0d busy/halted/fault=%b%b%b required %h 0 000",
                         instruction, pc, busy, halted, fault, NOP);
    end
    @(negedge clk);
    rst = 1'b0;
    run_check(3, 3, 0, 0);
    run_check(0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) prog[i] = mk(4'($urandom_range(0, 3)), 3'($urandom), 3'($urandom));
      if (it % 3 != 0) prog[$urandom_range(1, 15)] = mk(OP_HALT, 3'd0, 3'd0);
      if (it == 4) prog[$urandom_range(1, 5)] = mk(4'($urandom_range(4, 13)), 3'($urandom), 3'($urandom));
      load_program();
      run_check(3, 3, 1, 0);
    end
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    int got_c;
    for (int i = 0; i < 16; i++) prog[i] = mk(OP_LOAD, 3'(i), 3'd0);
    prog[4] = mk(OP_HALT, 3'd0, 3'd0);
    load_program();
    step_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got_c = -1;
      for (int c = 0; c < 10 && got_c < 0; c++) begin
        @(negedge clk);
        start = 1'b0; step = 1'b0;
        if (instruction !== NOP) got_c = c;
      end
      n_tests++;
      if (got_c != 1 || pc !== 4'(k)) begin
        n_fail++; $display("FAIL step_issue[%0d]: cycle %0d pc=%0d required 1 %0d", k, got_c, pc, k);
      end
      @(negedge clk); done_in = 1'b1;
      @(negedge clk); done_in = 1'b0;
      for (int c = 0; c < 3; c++) begin
        n_tests++;
        if (busy !== 1'b1 || instruction !== NOP || pc !== 4'(k + 1)) begin
          n_fail++; $display("FAIL step_pause[%0d]: busy=%b instr=%h pc=%0d required 1 %h %0d",
                             k, busy, instruction, pc, NOP, k + 1);
        end
        @(negedge clk);
      end
      if (k < 2) step = 1'b1;
      else if (k == 2) step = 1'b1;
      else step_en = 1'b0;
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (halted !== 1'b1 || pc !== 4'd4) begin
      n_fail++; $display("FAIL step_end: halted=%b pc=%0d required 1 4", halted, pc);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_move_halt();
    test_add();
    test_timeout();
    test_no_wrap();
    test_same_cycle_write();
    test_reset_mid_run();
    test_random();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
